// File: rtl/spectrum_frame_buffer.sv
// Parses sync-prefixed spectrum frames from the receive FIFO into a double-buffered
// bin store with per-bin peak hold, read combinationally by the VGA side.
module spectrum_frame_buffer #(
  parameter int unsigned NUM_BINS          = 32,
  parameter int unsigned BIN_IDX_W         = 6,
  parameter logic [7:0]  SYNC_BYTE         = 8'hFF,
  parameter int unsigned PEAK_DECAY_FRAMES = 4
) (
  input  logic                 cclk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [BIN_IDX_W-1:0] rd_bin,
  output logic [7:0]           rd_level,
  output logic [7:0]           rd_peak,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic [7:0]           err_count
);

  localparam int unsigned          DEPTH      = 1 << BIN_IDX_W;
  localparam logic [BIN_IDX_W-1:0] LAST_IDX   = BIN_IDX_W'(NUM_BINS - 1);
  localparam logic [7:0]           DECAY_LAST = 8'(PEAK_DECAY_FRAMES - 1);

  typedef enum logic [1:0] {HUNT, COLLECT, SWAP} state_t;

  state_t               state, state_next;
  logic [BIN_IDX_W-1:0] idx;
  logic [7:0]           decay_cnt;
  logic [7:0]           back  [DEPTH];
  logic [7:0]           front [DEPTH];
  logic [7:0]           peak  [DEPTH];
  logic [7:0]           peak_next [DEPTH];
  logic                 accept, is_sync, decay_now;
  logic                 start, resync, load_en, swap_en, ready_next;

  assign accept    = rx_valid & rx_ready;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign decay_now = (decay_cnt == DECAY_LAST);

  always_ff @(posedge cclk or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (accept && is_sync) state_next = COLLECT;
      COLLECT: if (accept && !is_sync && idx == LAST_IDX) state_next = SWAP;
      SWAP:    state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    start   = 1'b0;
    resync  = 1'b0;
    load_en = 1'b0;
    swap_en = 1'b0;
    case (state)
      HUNT:    start = accept && is_sync;
      COLLECT: begin
        resync  = accept && is_sync;
        load_en = accept && !is_sync;
      end
      SWAP:    swap_en = 1'b1;
      default: ;
    endcase
    ready_next = (state_next != SWAP);
  end

  // Candidate peak: optionally decayed old peak versus the incoming frame
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] p;
      p = (decay_now && peak[i] != 8'd0) ? peak[i] - 8'd1 : peak[i];
      peak_next[i] = (back[i] > p) ? back[i] : p;
    end
  end

  always_ff @(posedge cclk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
      for (int i = 0; i < DEPTH; i++) back[i] <= 8'd0;
    end else begin
      if (start || resync) idx <= '0;
      else if (load_en && idx != LAST_IDX) idx <= idx + BIN_IDX_W'(1);
      if (load_en) back[idx] <= rx_data;
    end
  end

  always_ff @(posedge cclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        front[i] <= 8'd0;
        peak[i]  <= 8'd0;
      end
      decay_cnt   <= 8'd0;
      frame_count <= 16'd0;
      err_count   <= 8'd0;
      frame_done  <= 1'b0;
      rx_ready    <= 1'b0;
    end else begin
      rx_ready   <= ready_next;
      frame_done <= swap_en;
      if (resync && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (swap_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          front[i] <= back[i];
          peak[i]  <= peak_next[i];
        end
        decay_cnt   <= decay_now ? 8'd0 : decay_cnt + 8'd1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Out-of-range bins read as zero
  always_comb begin
    rd_level = 8'd0;
    rd_peak  = 8'd0;
    if (32'(rd_bin) < NUM_BINS) begin
      rd_level = front[rd_bin];
      rd_peak  = peak[rd_bin];
    end
  end

endmodule
